// File: rtl/j_snapread.sv
// ---------------------------------------------------------------------------
// j_snapread
// Bus-side reader for Jerry's enable-latched 32-bit status/counter registers.
// Presents the registers over a 16-bit read port. A low-word read snapshots
// the full 32-bit source so that a following high-word read of the same
// register returns a value coherent with the low word. A programmable number
// of wait states is inserted between accepting a read and the ack pulse.
//
// Ports:
//   sys_clk  in   system clock, all state changes on the rising edge
//   reset    in   asynchronous active-high reset
//   src      in   live register values, register i at [32i+31:32i]
//   rd       in   read request strobe (accepted only when idle)
//   addr     in   bit0 = word select (0 low, 1 high), [IBITS:1] = index
//   dout     out  read data, valid with ack and held afterwards
//   ack      out  one-cycle read-complete pulse
//   busy     out  high from the cycle after accept through the ack cycle
//   miss     out  with ack: high read had no matching snapshot
//   dpar     out  even parity of dout (only with J_SNAPREAD_PARITY_EN)
//
// Optional feature macro: J_SNAPREAD_PARITY_EN
//   Adds the dpar output and a 2-bit parity store alongside the snapshot.
// ---------------------------------------------------------------------------
module j_snapread #(
  parameter int NREG     = 4,
  parameter int IBITS    = 2,
  parameter int WAIT_CYC = 1
) (
  input  logic                sys_clk,
  input  logic                reset,
  input  logic [32*NREG-1:0]  src,
  input  logic                rd,
  input  logic [IBITS:0]      addr,
  output logic [15:0]         dout,
  output logic                ack,
  output logic                busy,
  output logic                miss
`ifdef J_SNAPREAD_PARITY_EN
  ,
  output logic                dpar
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam int             WAIT_LD_I = (WAIT_CYC > 0) ? (WAIT_CYC - 1) : 0;
  localparam logic [2:0]     WAIT_LD   = WAIT_LD_I[2:0];
  localparam logic [IBITS:0] NREG_W    = (IBITS + 1)'(NREG);

`ifdef J_SNAPREAD_PARITY_EN
  // Even parity of a 16-bit word.
  function automatic logic f_par16(input logic [15:0] d);
    return ^d;
  endfunction
`endif

  state_t             r_state;
  state_t             w_next;
  logic               w_accept;
  logic [2:0]         r_cnt;

  logic [IBITS-1:0]   w_idx;
  logic               w_hi;
  logic               w_in_range;
  logic               w_hit;
  logic [31:0]        w_sel;
  logic [15:0]        w_rdata;
  logic               w_rmiss;

  logic [15:0]        r_rdata;
  logic               r_rmiss;
  logic [31:0]        r_hold;
  logic [IBITS-1:0]   r_tag;
  logic               r_hvalid;

  logic [15:0]        w_dout_src;
  logic               w_miss_src;

  logic [15:0]        r_dout;
  logic               r_ack;
  logic               r_busy;
  logic               r_miss;

`ifdef J_SNAPREAD_PARITY_EN
  logic [1:0]         r_hpar;
  logic               w_rpar;
  logic               r_rpar;
  logic               w_par_src;
  logic               r_dpar;
`endif

  assign w_idx      = addr[IBITS:1];
  assign w_hi       = addr[0];
  assign w_in_range = ({1'b0, w_idx} < NREG_W);
  assign w_hit      = r_hvalid && (r_tag == w_idx);

  // Register select: AND-OR mux over the valid registers; out-of-range gives 0.
  always_comb begin
    w_sel = 32'h0000_0000;
    for (int i = 0; i < NREG; i++) begin
      w_sel = w_sel | (src[32*i +: 32] & {32{w_idx == IBITS'(i)}});
    end
  end

  // Result word and miss flag for the read being accepted this cycle.
  always_comb begin
    w_rdata = 16'h0000;
    w_rmiss = 1'b0;
    if (!w_in_range) begin
      w_rdata = 16'h0000;
      w_rmiss = 1'b0;
    end else if (!w_hi) begin
      w_rdata = w_sel[15:0];
      w_rmiss = 1'b0;
    end else if (w_hit) begin
      w_rdata = r_hold[31:16];
      w_rmiss = 1'b0;
    end else begin
      w_rdata = w_sel[31:16];
      w_rmiss = 1'b1;
    end
  end

`ifdef J_SNAPREAD_PARITY_EN
  // Parity of the accepted word; a snapshot hit reuses the stored parity.
  always_comb begin
    w_rpar = 1'b0;
    if (!w_in_range) begin
      w_rpar = 1'b0;
    end else if (!w_hi) begin
      w_rpar = f_par16(w_sel[15:0]);
    end else if (w_hit) begin
      w_rpar = r_hpar[1];
    end else begin
      w_rpar = f_par16(w_sel[31:16]);
    end
  end
`endif

  // Next-state logic: IDLE -> (WAIT) -> ACK -> IDLE.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rd) begin
          w_accept = 1'b1;
          w_next   = (WAIT_CYC > 0) ? S_WAIT : S_ACK;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt == 3'd0) begin
          w_next = S_ACK;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Wait-state counter, loaded at accept and counting down in WAIT.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 3'd0;
    end else if (w_accept) begin
      r_cnt <= WAIT_LD;
    end else if ((r_state == S_WAIT) && (r_cnt != 3'd0)) begin
      r_cnt <= r_cnt - 3'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Result captured at accept, consumed when entering ACK after wait states.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_rdata <= 16'h0000;
      r_rmiss <= 1'b0;
    end else if (w_accept) begin
      r_rdata <= w_rdata;
      r_rmiss <= w_rmiss;
    end else begin
      r_rdata <= r_rdata;
      r_rmiss <= r_rmiss;
    end
  end

  // Snapshot: a low read captures all 32 bits; a matching high read consumes it.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_hold   <= 32'h0000_0000;
      r_tag    <= '0;
      r_hvalid <= 1'b0;
    end else if (w_accept && w_in_range && !w_hi) begin
      r_hold   <= w_sel;
      r_tag    <= w_idx;
      r_hvalid <= 1'b1;
    end else if (w_accept && w_in_range && w_hi && w_hit) begin
      r_hold   <= r_hold;
      r_tag    <= r_tag;
      r_hvalid <= 1'b0;
    end else begin
      r_hold   <= r_hold;
      r_tag    <= r_tag;
      r_hvalid <= r_hvalid;
    end
  end

`ifdef J_SNAPREAD_PARITY_EN
  // Per-half parity stored with the snapshot, plus parity of the accepted word.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_hpar <= 2'b00;
      r_rpar <= 1'b0;
    end else if (w_accept && w_in_range && !w_hi) begin
      r_hpar <= {f_par16(w_sel[31:16]), f_par16(w_sel[15:0])};
      r_rpar <= w_rpar;
    end else if (w_accept) begin
      r_hpar <= r_hpar;
      r_rpar <= w_rpar;
    end else begin
      r_hpar <= r_hpar;
      r_rpar <= r_rpar;
    end
  end
`endif

  // With no wait states ACK follows IDLE directly, so take the live result.
  assign w_dout_src = (r_state == S_IDLE) ? w_rdata : r_rdata;
  assign w_miss_src = (r_state == S_IDLE) ? w_rmiss : r_rmiss;
`ifdef J_SNAPREAD_PARITY_EN
  assign w_par_src  = (r_state == S_IDLE) ? w_rpar  : r_rpar;
`endif

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_dout <= 16'h0000;
      r_ack  <= 1'b0;
      r_busy <= 1'b0;
      r_miss <= 1'b0;
    end else if (w_next == S_ACK) begin
      r_dout <= w_dout_src;
      r_ack  <= 1'b1;
      r_busy <= 1'b1;
      r_miss <= w_miss_src;
    end else begin
      r_dout <= r_dout;
      r_ack  <= 1'b0;
      r_busy <= (w_next != S_IDLE);
      r_miss <= 1'b0;
    end
  end

`ifdef J_SNAPREAD_PARITY_EN
  // Parity output, updated together with dout.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_dpar <= 1'b0;
    end else if (w_next == S_ACK) begin
      r_dpar <= w_par_src;
    end else begin
      r_dpar <= r_dpar;
    end
  end

  assign dpar = r_dpar;
`endif

  assign dout = r_dout;
  assign ack  = r_ack;
  assign busy = r_busy;
  assign miss = r_miss;

endmodule
